// File: rtl/seso_ctrl_pkg.sv
// Shared state encoding, opcode values and instruction field bounds
// for the SESO multi-cycle control path.
package seso_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [2:0] OP_ALU   = 3'b000;
    localparam logic [2:0] OP_ALUI  = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_BR    = 3'b100;
    localparam logic [2:0] OP_NOP5  = 3'b101;
    localparam logic [2:0] OP_NOP6  = 3'b110;
    localparam logic [2:0] OP_HALT  = 3'b111;

    localparam int OPC_MSB = 8;
    localparam int OPC_LSB = 6;

    function automatic logic is_nop(input logic [2:0] op);
        return (op == OP_NOP5) || (op == OP_NOP6);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Down-counter bounding how long the sequencer waits in MEM for Mem_ready.
// expired is high on the MEM_TIMEOUT-th waiting cycle since the last clear.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic Clk,
    input  logic Reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam logic [7:0] LOAD_VAL = 8'(MEM_TIMEOUT - 1);

    logic [7:0] remain_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            remain_q <= LOAD_VAL;
        end else if (clear) begin
            remain_q <= LOAD_VAL;
        end else if (tick && (remain_q != 8'd0)) begin
            remain_q <= remain_q - 8'd1;
        end
    end

    assign expired = (remain_q == 8'd0);

endmodule

// File: rtl/datapath_sequencer.sv
// Multi-cycle control FSM for the 8-bit SESO datapath: fetch/decode/exec/
// mem/writeback sequencing, mux selects, write strobes and memory handshake.
//
// state  | meaning
// IDLE   | waiting for Start, all outputs low
// FETCH  | load IR, latch opcode
// DECODE | route by opcode
// EXEC   | ALU operation; branches resolve and retire here
// MEM    | data memory request, waits for Mem_ready with timeout
// WB     | register writeback, PC advance, retire
// HALT   | Done high until Reset (entered on HALT opcode or MEM timeout)
module datapath_sequencer
    import seso_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [8:0]  Instr,
    input  logic        Alu_zero,
    input  logic        Mem_ready,
    output logic        PCmux_en,
    output logic        ALUmux_en,
    output logic        DataMemmux_en,
    output logic        Pc_write,
    output logic        Ir_write,
    output logic        Reg_write,
    output logic        Mem_req,
    output logic        Mem_write,
    output logic        Done,
    output logic        Fault,
    output logic [2:0]  State,
    output logic [15:0] Retired
);

    state_t      state_q, state_d;
    logic [2:0]  op_q;
    logic        retire;
    logic        fault_set;
    logic        timer_expired;
    logic        unused_instr_bits;

    assign unused_instr_bits = ^Instr[OPC_LSB-1:0];

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .Clk     (Clk),
        .Reset   (Reset),
        .clear   (state_q != S_MEM),
        .tick    ((state_q == S_MEM) && !Mem_ready),
        .expired (timer_expired)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            op_q    <= 3'b000;
            Retired <= 16'd0;
            Fault   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) begin
                op_q <= Instr[OPC_MSB:OPC_LSB];
            end
            if (retire) begin
                Retired <= Retired + 16'd1;
            end
            if (fault_set) begin
                Fault <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        PCmux_en      = 1'b0;
        ALUmux_en     = 1'b0;
        DataMemmux_en = 1'b0;
        Pc_write      = 1'b0;
        Ir_write      = 1'b0;
        Reg_write     = 1'b0;
        Mem_req       = 1'b0;
        Mem_write     = 1'b0;
        Done          = 1'b0;
        retire        = 1'b0;
        fault_set     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (Start) state_d = S_FETCH;
            end
            S_FETCH: begin
                Ir_write = 1'b1;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                if (is_nop(op_q))        state_d = S_WB;
                else if (op_q == OP_HALT) state_d = S_HALT;
                else                      state_d = S_EXEC;
            end
            S_EXEC: begin
                ALUmux_en = (op_q == OP_ALUI) || (op_q == OP_LOAD) || (op_q == OP_STORE);
                if (op_q == OP_BR) begin
                    Pc_write = 1'b1;
                    PCmux_en = Alu_zero;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                Mem_req   = 1'b1;
                Mem_write = (op_q == OP_STORE);
                // A ready response in the last allowed cycle still completes.
                if (Mem_ready) begin
                    state_d = S_WB;
                end else if (timer_expired) begin
                    state_d   = S_HALT;
                    fault_set = 1'b1;
                end
            end
            S_WB: begin
                Pc_write      = 1'b1;
                Reg_write     = (op_q == OP_ALU) || (op_q == OP_ALUI) || (op_q == OP_LOAD);
                DataMemmux_en = (op_q == OP_LOAD);
                retire        = 1'b1;
                state_d       = S_FETCH;
            end
            S_HALT: begin
                Done = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign State = state_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: table of instructions with
// hand-derived expectations through a scoreboard queue, plus corner sequences.
module tb_datapath_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [8:0]  Instr = 9'd0;
    logic        Alu_zero = 1'b0;
    logic        Mem_ready = 1'b0;
    logic        PCmux_en, ALUmux_en, DataMemmux_en;
    logic        Pc_write, Ir_write, Reg_write;
    logic        Mem_req, Mem_write, Done, Fault;
    logic [2:0]  State;
    logic [15:0] Retired;

    int total = 0;
    int bad = 0;

    always #5 Clk = ~Clk;

    datapath_sequencer #(.MEM_TIMEOUT(4)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Start         (Start),
        .Instr         (Instr),
        .Alu_zero      (Alu_zero),
        .Mem_ready     (Mem_ready),
        .PCmux_en      (PCmux_en),
        .ALUmux_en     (ALUmux_en),
        .DataMemmux_en (DataMemmux_en),
        .Pc_write      (Pc_write),
        .Ir_write      (Ir_write),
        .Reg_write     (Reg_write),
        .Mem_req       (Mem_req),
        .Mem_write     (Mem_write),
        .Done          (Done),
        .Fault         (Fault),
        .State         (State),
        .Retired       (Retired)
    );

    typedef struct {
        logic [2:0] op;
        logic       zero;
        int         w;
        int         cycles;
        int         reg_wr;
        int         dmux;
        int         req_n;
        int         memw_n;
        int         alumux;
        int         pcmux;
    } vec_t;

    vec_t vecs[10];
    vec_t sb[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        int cycles, memcyc, reg_seen, dmux_seen, req_n, memw_n, alumux_x, pcmux_x, pcw_n;
        logic [15:0] ret0;
        logic [2:0] st;
        Instr    = {v.op, 6'h2a};
        Alu_zero = v.zero;
        sb.push_back(v);
        ret0 = Retired;
        cycles = 0; memcyc = 0; reg_seen = 0; dmux_seen = 0;
        req_n = 0; memw_n = 0; alumux_x = 0; pcmux_x = 0; pcw_n = 0;
        chk("fetch_ir_write", int'(Ir_write), 1);
        do begin
            tick();
            cycles++;
            st = State;
            Mem_ready = (st == 3'd4) && (memcyc == v.w);
            #1;
            if (st != 3'd1) begin
                if (Reg_write)     reg_seen = 1;
                if (DataMemmux_en) dmux_seen = 1;
                if (Mem_req)       req_n++;
                if (Mem_write)     memw_n++;
                if (Pc_write)      pcw_n++;
                if (st == 3'd3 && ALUmux_en) alumux_x = 1;
                if (st == 3'd3 && PCmux_en)  pcmux_x = 1;
            end
            if (st == 3'd4) memcyc++;
        end while (st != 3'd1 && cycles < 40);
        Mem_ready = 1'b0;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("op%0d_cycles", e.op), cycles, e.cycles);
            chk($sformatf("op%0d_reg_write", e.op), reg_seen, e.reg_wr);
            chk($sformatf("op%0d_dmux", e.op), dmux_seen, e.dmux);
            chk($sformatf("op%0d_mem_req_cycles", e.op), req_n, e.req_n);
            chk($sformatf("op%0d_mem_write_cycles", e.op), memw_n, e.memw_n);
            chk($sformatf("op%0d_alumux_exec", e.op), alumux_x, e.alumux);
            chk($sformatf("op%0d_pcmux_exec", e.op), pcmux_x, e.pcmux);
            chk($sformatf("op%0d_pc_write", e.op), pcw_n, 1);
            chk($sformatf("op%0d_retired", e.op), int'(Retired), int'(ret0 + 16'd1));
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    task automatic do_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("start_to_fetch", int'(State), 1);
    endtask

    initial begin
        int mem_n;
        int guard;
        //            op      z     w  cyc rw dm req mw alu pcm
        vecs[0] = '{3'b000, 1'b0, 0, 4, 1, 0, 0, 0, 0, 0};
        vecs[1] = '{3'b001, 1'b0, 0, 4, 1, 0, 0, 0, 1, 0};
        vecs[2] = '{3'b010, 1'b0, 2, 7, 1, 1, 3, 0, 1, 0};
        vecs[3] = '{3'b011, 1'b0, 0, 5, 0, 0, 1, 1, 1, 0};
        vecs[4] = '{3'b100, 1'b1, 0, 3, 0, 0, 0, 0, 0, 1};
        vecs[5] = '{3'b100, 1'b0, 0, 3, 0, 0, 0, 0, 0, 0};
        vecs[6] = '{3'b101, 1'b0, 0, 3, 0, 0, 0, 0, 0, 0};
        vecs[7] = '{3'b110, 1'b0, 0, 3, 0, 0, 0, 0, 0, 0};
        vecs[8] = '{3'b010, 1'b0, 0, 5, 1, 1, 1, 0, 1, 0};
        // four MEM cycles with MEM_TIMEOUT=4: ready on the last one still wins
        vecs[9] = '{3'b011, 1'b0, 3, 8, 0, 0, 4, 4, 1, 0};

        do_reset();
        chk("reset_state", int'(State), 0);
        chk("reset_retired", int'(Retired), 0);
        chk("reset_fault", int'(Fault), 0);
        chk("reset_outputs", int'({PCmux_en, ALUmux_en, DataMemmux_en, Pc_write, Ir_write,
                                   Reg_write, Mem_req, Mem_write, Done}), 0);
        tick();
        chk("idle_hold", int'(State), 0);

        do_start();
        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i]);
        end
        chk("retired_after_table", int'(Retired), 10);

        Instr = {3'b111, 6'h00};
        tick();
        chk("halt_decode", int'(State), 2);
        tick();
        chk("halt_state", int'(State), 6);
        chk("halt_done", int'(Done), 1);
        chk("halt_no_fault", int'(Fault), 0);
        Start = 1'b1;
        tick();
        tick();
        Start = 1'b0;
        chk("halt_ignores_start", int'(State), 6);

        do_reset();
        do_start();
        Instr = {3'b010, 6'h00};
        Mem_ready = 1'b0;
        mem_n = 0;
        guard = 0;
        do begin
            tick();
            guard++;
            if (State == 3'd4) mem_n++;
        end while (State != 3'd6 && guard < 30);
        chk("timeout_mem_cycles", mem_n, 4);
        chk("timeout_state", int'(State), 6);
        chk("timeout_fault", int'(Fault), 1);
        chk("timeout_done", int'(Done), 1);
        chk("timeout_no_req", int'(Mem_req), 0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("timeout_ignores_start", int'(State), 6);
        chk("fault_sticky", int'(Fault), 1);
        do_reset();
        chk("fault_cleared", int'(Fault), 0);
        chk("post_fault_idle", int'(State), 0);

        do_start();
        Instr = {3'b010, 6'h00};
        tick();
        tick();
        tick();
        chk("midmem_state", int'(State), 4);
        chk("midmem_req", int'(Mem_req), 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("midmem_reset_state", int'(State), 0);
        chk("midmem_reset_req", int'(Mem_req), 0);
        chk("midmem_retired", int'(Retired), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
